// File: rtl/led_pkg.sv
// led_pkg: shared constants and colour type for the RGB PWM block
package led_pkg;
  localparam int COLOR_W = 8;
  localparam logic [COLOR_W-1:0] PWM_LAST = 8'd254;
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;
endpackage

// File: rtl/led_gamma.sv
// led_gamma: combinational single-channel gamma squarer g = (c*c + 255) >> 8
// Ports: c (channel in), g (mapped channel out). Built only with LED_RGB_PWM_GAMMA_EN.
`ifdef LED_RGB_PWM_GAMMA_EN
module led_gamma
  import led_pkg::*;
(
  input  logic [COLOR_W-1:0] c,
  output logic [COLOR_W-1:0] g
);
  logic [2*COLOR_W-1:0] sq;
  always_comb begin
    sq = {{COLOR_W{1'b0}}, c} * {{COLOR_W{1'b0}}, c} + 16'd255;
    g = sq[2*COLOR_W-1:COLOR_W];
  end
endmodule
`endif

// File: rtl/led_rgb_pwm.sv
// led_rgb_pwm: 3-channel active-low LED PWM with a one-deep colour update slot applied at period boundaries
// Ports: clk, reset_ (async active-low); color_valid/color_ready handshake with color_r/g/b;
//        period_start pulse; led_r_/led_g_/led_b_ active-low drives.
// Optional: define LED_RGB_PWM_GAMMA_EN to gamma-map accepted colours.
module led_rgb_pwm
  import led_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               color_valid,
  output logic               color_ready,
  input  logic [COLOR_W-1:0] color_r,
  input  logic [COLOR_W-1:0] color_g,
  input  logic [COLOR_W-1:0] color_b,
  output logic               period_start,
  output logic               led_r_,
  output logic               led_g_,
  output logic               led_b_
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("led_rgb_pwm: PRESCALE must be >= 1");
    end
  endgenerate
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [COLOR_W-1:0] pwm_cnt_q, pwm_cnt_d;
  rgb_t duty_q, duty_d, pend_q, pend_d, color_in;
  logic pending_full_q, pending_full_d;
  logic [2:0] led_q, led_d;
  logic period_start_q, period_start_d;
  logic tick, boundary, accept;
`ifdef LED_RGB_PWM_GAMMA_EN
  led_gamma u_gamma_r (.c(color_r), .g(color_in.r));
  led_gamma u_gamma_g (.c(color_g), .g(color_in.g));
  led_gamma u_gamma_b (.c(color_b), .g(color_in.b));
`else
  always_comb color_in = {color_r, color_g, color_b};
`endif
  // An update accepted on a boundary cycle lands in pending and waits a full period,
  // since the slot is empty and the consuming transfer only looks at the old slot state.
  always_comb begin
    tick = pre_cnt_q == PRE_LAST;
    boundary = tick && pwm_cnt_q == PWM_LAST;
    accept = color_valid && !pending_full_q;
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = !tick ? pwm_cnt_q : boundary ? '0 : pwm_cnt_q + 1'b1;
    duty_d = boundary && pending_full_q ? pend_q : duty_q;
    pend_d = accept ? color_in : pend_q;
    pending_full_d = accept ? 1'b1 : boundary ? 1'b0 : pending_full_q;
    led_d = {!(pwm_cnt_q < duty_q.r), !(pwm_cnt_q < duty_q.g), !(pwm_cnt_q < duty_q.b)};
    period_start_d = pwm_cnt_q == '0 && pre_cnt_q == '0;
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      duty_q <= '0;
      pend_q <= '0;
      pending_full_q <= 1'b0;
      led_q <= 3'b111;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q <= duty_d;
      pend_q <= pend_d;
      pending_full_q <= pending_full_d;
      led_q <= led_d;
      period_start_q <= period_start_d;
    end
  end
  assign color_ready = !pending_full_q;
  assign period_start = period_start_q;
  assign led_r_ = led_q[2];
  assign led_g_ = led_q[1];
  assign led_b_ = led_q[0];
endmodule

// File: tb/tb_led_rgb_pwm.sv
// tb_led_rgb_pwm: table-driven and randomized checks of led_rgb_pwm against a period-arithmetic model
module tb_led_rgb_pwm;
  localparam int PS = 2;
  localparam int PER = 255 * PS;
  logic clk = 1'b0;
  logic reset_ = 1'b1;
  logic color_valid = 1'b0;
  logic [7:0] color_r = '0, color_g = '0, color_b = '0;
  logic color_ready, period_start, led_r_, led_g_, led_b_;
  led_rgb_pwm #(.PRESCALE(PS)) dut (
    .clk(clk), .reset_(reset_), .color_valid(color_valid), .color_ready(color_ready),
    .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .period_start(period_start), .led_r_(led_r_), .led_g_(led_g_), .led_b_(led_b_)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int cyc = 0;
  int cur[3] = '{0, 0, 0};
  int pend[3] = '{0, 0, 0};
  bit pend_v = 0;
  int pend_ap = 0;
  bit got_acc = 0;
  int acc_cyc = 0;
  typedef struct {int r, g, b, er, eg, eb;} vec_t;
  vec_t tbl[4];
  function automatic int gmap(int c);
`ifdef LED_RGB_PWM_GAMMA_EN
    return (c * c + 255) / 256;
`else
    return c;
`endif
  endfunction
  function automatic bit m_ready(int m);
    return !(pend_v && m / PER < pend_ap);
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // One clock: model the state of cycle cyc, which the DUT registers onto its pins at the edge.
  task automatic step();
    logic [4:0] exp;
    int pos;
    bit acc;
    if (pend_v && cyc / PER >= pend_ap) begin
      cur = pend;
      pend_v = 0;
    end
    pos = (cyc % PER) / PS;
    exp[4] = (cyc % PER) == 0;
    exp[2] = !(pos < cur[0]);
    exp[1] = !(pos < cur[1]);
    exp[0] = !(pos < cur[2]);
    acc = color_valid && m_ready(cyc);
    got_acc = acc;
    @(posedge clk);
    if (acc) begin
      pend_v = 1;
      pend = '{gmap(int'(color_r)), gmap(int'(color_g)), gmap(int'(color_b))};
      pend_ap = (cyc + 1) / PER + 1;
      acc_cyc = cyc;
    end
    cyc++;
    exp[3] = m_ready(cyc);
    #1;
    check("cycle_outputs", {period_start, color_ready, led_r_, led_g_, led_b_}, exp);
  endtask
  task automatic measure(int p, output int on[3]);
    on = '{0, 0, 0};
    while (cyc < p * PER) step();
    repeat (PER) begin
      step();
      on[0] += int'(!led_r_);
      on[1] += int'(!led_g_);
      on[2] += int'(!led_b_);
    end
  endtask
  task automatic offer(int r, int g, int b);
    int n;
    n = 0;
    color_r = 8'(r);
    color_g = 8'(g);
    color_b = 8'(b);
    color_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!got_acc && n < 3 * PER);
    color_valid = 1'b0;
    check("accept_timeout", 32'(got_acc), 1);
  endtask
  task automatic model_reset();
    cyc = 0;
    cur = '{0, 0, 0};
    pend_v = 0;
  endtask
  initial begin
    int on[3];
    int pa, q;
`ifdef LED_RGB_PWM_GAMMA_EN
    tbl[0] = '{255, 0, 128, 510, 0, 128};
    tbl[1] = '{10, 20, 1, 2, 4, 2};
    tbl[2] = '{16, 64, 254, 2, 32, 506};
    tbl[3] = '{0, 255, 1, 0, 510, 2};
`else
    tbl[0] = '{255, 0, 128, 510, 0, 256};
    tbl[1] = '{10, 20, 1, 20, 40, 2};
    tbl[2] = '{16, 64, 254, 32, 128, 508};
    tbl[3] = '{0, 255, 1, 0, 510, 2};
`endif
    #2 reset_ = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("reset_state", {period_start, color_ready, led_r_, led_g_, led_b_}, 5'b01111);
    reset_ = 1'b1;
    model_reset();
    step();
    check("first_period_start", 32'(period_start), 1);
    for (int i = 0; i < 4; i++) begin
      offer(tbl[i].r, tbl[i].g, tbl[i].b);
      measure(pend_ap, on);
      check("table_on_r", on[0], tbl[i].er);
      check("table_on_g", on[1], tbl[i].eg);
      check("table_on_b", on[2], tbl[i].eb);
    end
    offer(10, 0, 0);
    pa = pend_ap;
    color_r = 8'd20;
    color_valid = 1'b1;
    repeat (3) begin
      step();
      check("b2b_ready_low", 32'(color_ready), 0);
    end
    color_valid = 1'b0;
    offer(20, 0, 0);
    check("b2b_accept_cycle", acc_cyc, pa * PER);
    measure(pa, on);
    check("b2b_a_on", on[0], gmap(10) * PS);
    measure(pa + 1, on);
    check("b2b_b_on", on[0], gmap(20) * PS);
    while (cyc % PER != PER - 1) step();
    q = cyc / PER;
    color_r = 8'd200;
    color_valid = 1'b1;
    step();
    color_valid = 1'b0;
    check("collision_accept", 32'(got_acc), 1);
    measure(q + 1, on);
    check("collision_old_duty", on[0], gmap(20) * PS);
    measure(q + 2, on);
    check("collision_new_duty", on[0], gmap(200) * PS);
    repeat (8) begin
      repeat ($urandom_range(0, 700)) step();
      offer($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    measure(pend_ap, on);
    check("random_last_on_r", on[0], pend[0] * PS);
    offer(255, 255, 255);
    while (cyc < pend_ap * PER + 100) step();
    offer(1, 2, 3);
    repeat (5) step();
    #2 reset_ = 1'b0;
    #1;
    check("async_reset_leds", {color_ready, led_r_, led_g_, led_b_}, 4'b1111);
    repeat (3) @(posedge clk);
    #1;
    reset_ = 1'b1;
    model_reset();
    measure(1, on);
    check("post_reset_dark", on[0] + on[1] + on[2], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
